// File: rtl/swt16_pkg.sv
// Shared definitions for the SWT16 core.
//   - Default widths of the program memory, PC and IALU result bus.
//   - NOP encoding, which the decoder sees whenever fetch has nothing valid.
//   - Encodings for the fetch FSM states.
package swt16_pkg;

  localparam int unsigned PMEM_ADDR_WIDTH = 12;
  localparam int unsigned PMEM_WORD_WIDTH = 16;
  localparam int unsigned PC_WIDTH        = 12;
  localparam int unsigned IALU_WORD_WIDTH = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO holding fetched {instr, pc} entries.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        drop all entries; takes priority over push/pop
//   push_i         write data_i at the tail
//   pop_i          retire the head entry
//   data_i         entry to push
//   data_o         head entry (meaningless when count_o == 0)
//   count_o        number of stored entries, 0..2
module fetch_fifo2 #(
  parameter int unsigned Width = 28
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q covers them.
  // A push while full with a simultaneous pop lands on the slot being retired.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !clear_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the SWT16 core.
// Owns the PC, issues word reads to a 1-cycle-latency program memory, buffers returned words
// with their PC in a 2-entry FIFO and presents the head to the decoder. A jump flushes all
// stale words and restarts fetch at the target.
// Ports:
//   clock, reset    clock; asynchronous active-low reset
//   out_pmem_en     read request this cycle
//   out_pmem_addr   read address (= PC)
//   in_pmem_data    read data, valid the cycle after out_pmem_en
//   in_jump         redirect request
//   in_jump_target  redirect target; only the low PC_WIDTH bits are used
//   in_stall        decoder cannot accept the presented word
//   out_valid       out_instr/out_pc hold a real instruction
//   out_instr       instruction word (NOP when !out_valid)
//   out_pc          PC of out_instr (0 when !out_valid)
import swt16_pkg::*;

module fetch_unit #(
  parameter int unsigned PMEM_ADDR_WIDTH = swt16_pkg::PMEM_ADDR_WIDTH,
  parameter int unsigned PMEM_WORD_WIDTH = swt16_pkg::PMEM_WORD_WIDTH,
  parameter int unsigned PC_WIDTH        = swt16_pkg::PC_WIDTH,
  parameter int unsigned IALU_WORD_WIDTH = swt16_pkg::IALU_WORD_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       out_pmem_en,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
  input  logic                       in_jump,
  input  logic [IALU_WORD_WIDTH-1:0] in_jump_target,
  input  logic                       in_stall,
  output logic                       out_valid,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc
);

  localparam int unsigned EntryWidth = PMEM_WORD_WIDTH + PC_WIDTH;

  fetch_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  issued_pc_q, issued_pc_d;
  logic                 inflight_q, inflight_d;

  logic [1:0]            fifo_count;
  logic [EntryWidth-1:0] fifo_head;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  // Upper target bits are architecturally ignored.
  logic unused_target_hi;
  assign unused_target_hi = ^in_jump_target[IALU_WORD_WIDTH-1:PC_WIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:          state_d = ST_RUN;
      ST_RUN, ST_REDIR: state_d = in_jump ? ST_REDIR : ST_RUN;
      default:          state_d = ST_BOOT;
    endcase
  end

  // Words already held plus the one returning this cycle, less what leaves now, must leave
  // room for the word this issue will return next cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

  always_comb begin
    out_valid = (fifo_count != 2'd0) && (state_q != ST_REDIR);
    pop       = out_valid && !in_stall && !in_jump;
    push      = inflight_q && !in_jump;
    issue     = (state_q != ST_BOOT) && !in_jump && (occupancy <= 3'd1 + {2'b00, pop});

    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = issue;
    if (in_jump) begin
      pc_d = in_jump_target[PC_WIDTH-1:0];
    end else if (issue) begin
      pc_d        = pc_q + 1'b1;
      issued_pc_d = pc_q;
    end

    out_instr = out_valid ? fifo_head[EntryWidth-1:PC_WIDTH] : PMEM_WORD_WIDTH'(NOP_INSTR);
    out_pc    = out_valid ? fifo_head[PC_WIDTH-1:0] : '0;
  end

  assign out_pmem_en   = issue;
  assign out_pmem_addr = pc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= '0;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end

  fetch_fifo2 #(
    .Width (EntryWidth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (in_jump),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({in_pmem_data, issued_pc_q}),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/jump traffic, checked every
// cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        out_pmem_en;
  logic [11:0] out_pmem_addr;
  logic [15:0] in_pmem_data;
  logic        in_jump;
  logic [15:0] in_jump_target;
  logic        in_stall;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [11:0] out_pc;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .out_pmem_en    (out_pmem_en),
    .out_pmem_addr  (out_pmem_addr),
    .in_pmem_data   (in_pmem_data),
    .in_jump        (in_jump),
    .in_jump_target (in_jump_target),
    .in_stall       (in_stall),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous program memory, 1-cycle read latency.
  logic [15:0] pmem [4096];
  initial in_pmem_data = 16'h0000;
  always @(posedge clock) begin
    if (out_pmem_en) in_pmem_data <= pmem[out_pmem_addr];
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a queue of fetched words plus the PC and the one outstanding read.
  typedef struct {
    logic [15:0] instr;
    logic [11:0] pc;
  } entry_t;

  entry_t      m_q[$];
  bit          m_booted;
  bit          m_redir;
  bit          m_inflight;
  logic [11:0] m_pc;
  logic [11:0] m_ipc;

  task automatic model_reset();
    m_q.delete();
    m_booted   = 0;
    m_redir    = 0;
    m_inflight = 0;
    m_pc       = 12'h000;
    m_ipc      = 12'h000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_instr"}, {16'd0, out_instr}, 32'd0);
    check({tag, "_pc"}, {20'd0, out_pc}, 32'd0);
    check({tag, "_en"}, {31'd0, out_pmem_en}, 32'd0);
    check({tag, "_addr"}, {20'd0, out_pmem_addr}, 32'd0);
  endtask

  // Called just after a rising edge: drive inputs, compare outputs, advance the model, wait.
  task automatic cycle(input logic j, input logic s, input logic [15:0] t);
    bit          e_valid;
    bit          e_pop;
    bit          e_en;
    logic [15:0] e_instr;
    logic [11:0] e_pc;
    int          room;
    in_jump        = j;
    in_stall       = s;
    in_jump_target = t;
    #1;
    e_valid = m_booted && !m_redir && (m_q.size() != 0);
    e_instr = e_valid ? m_q[0].instr : 16'h0000;
    e_pc    = e_valid ? m_q[0].pc : 12'h000;
    e_pop   = e_valid && !s && !j;
    room    = m_q.size() + int'(m_inflight) - int'(e_pop);
    e_en    = m_booted && !j && (room <= 1);
    check("valid", {31'd0, out_valid}, {31'd0, e_valid});
    check("instr", {16'd0, out_instr}, {16'd0, e_instr});
    check("pc", {20'd0, out_pc}, {20'd0, e_pc});
    check("pmem_en", {31'd0, out_pmem_en}, {31'd0, e_en});
    check("pmem_addr", {20'd0, out_pmem_addr}, {20'd0, m_pc});

    if (!m_booted) begin
      m_booted = 1;
    end else if (j) begin
      m_q.delete();
      m_inflight = 0;
      m_pc       = t[11:0];
      m_redir    = 1;
    end else begin
      m_redir = 0;
      if (e_pop) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back('{instr: pmem[m_ipc], pc: m_ipc});
      if (e_en) begin
        m_ipc      = m_pc;
        m_pc       = m_pc + 12'h001;
        m_inflight = 1;
      end else begin
        m_inflight = 0;
      end
      if (m_q.size() > 2) check("model_depth", m_q.size(), 2);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    reset          = 1'b0;
    in_jump        = 1'b0;
    in_stall       = 1'b0;
    in_jump_target = 16'h0000;
    for (int i = 0; i < 4096; i++) pmem[i] = 16'($urandom);
    pmem[0]      = 16'h1111;
    pmem[1]      = 16'h2222;
    pmem[2]      = 16'h3333;
    pmem[3]      = 16'h4444;
    pmem[12'h123] = 16'hC123;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Boot and stream from address 0.
    repeat (6) cycle(1'b0, 1'b0, 16'h0000);
    // Stall while valid, then release.
    repeat (3) cycle(1'b0, 1'b1, 16'h0000);
    repeat (4) cycle(1'b0, 1'b0, 16'h0000);
    // Fill the FIFO, then jump with upper target bits set.
    repeat (3) cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b1, 1'b0, 16'hF123);
    repeat (5) cycle(1'b0, 1'b0, 16'h0000);
    // PC wrap through 0xFFF.
    cycle(1'b1, 1'b0, 16'h0FFE);
    repeat (7) cycle(1'b0, 1'b0, 16'h0000);
    // Jump with stall, then back-to-back jumps.
    repeat (2) cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b1, 1'b1, 16'h0200);
    cycle(1'b1, 1'b0, 16'h0300);
    cycle(1'b1, 1'b0, 16'h0400);
    repeat (5) cycle(1'b0, 1'b0, 16'h0000);

    // Asynchronous reset mid-stream with a read outstanding.
    repeat (3) cycle(1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clock);
    #1;
    check_reset_outputs("held_reset");
    reset = 1'b1;
    repeat (6) cycle(1'b0, 1'b0, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        j;
      logic        s;
      logic [15:0] t;
      j = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0) t = 16'($urandom_range(0, 15)) + 16'hAFF8;
      else t = 16'($urandom);
      cycle(j, s, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
